sid_i2s_tx: RTL and testbench

- Consumes the 16-bit mixed voice sample stream produced by the SID at the 1 MHz phase rate.
- Decimates the stream by box-car averaging of 2^DECIM_LOG2 samples.
- Buffers one decimated sample and serializes it as mono 16-bit I2S (same sample on left and right) toward the board audio DAC.
- BCLK and LRCLK are generated from the system clock.

---
 rtl/sid_i2s_tx.sv | 136 +++++++++++++
 tb/tb_sid_i2s_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_i2s_tx.sv
// sid_i2s_tx: box-car decimator for the SID voice mix feeding a mono 16-bit
// I2S transmitter (same sample on both channels), with BCLK/LRCLK derived from clk.
`default_nettype none

module sid_i2s_tx #(
    parameter int BCLK_DIV   = 8,
    parameter int DECIM_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_sample,
    input  logic        i_sample_valid,
    output logic        o_i2s_bclk,
    output logic        o_i2s_lrclk,
    output logic        o_i2s_sdata,
    output logic        o_overrun,
    output logic        o_underrun
);

    localparam int ACC_W = 16 + DECIM_LOG2;
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic signed [ACC_W-1:0]  acc_q;
    logic [DECIM_LOG2-1:0]    n_q;
    logic [15:0]              hold_q;
    logic                     pend_q;
    logic [15:0]              out_q;
    logic [DIV_W-1:0]         div_q;
    logic [5:0]               f_q;
    logic                     bclk_q;
    logic                     lrclk_q;
    logic                     sdata_q;
    logic                     over_q;
    logic                     under_q;

    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  avg_d;
    logic [5:0]               f_d;
    logic                     div_wrap;
    logic                     fall_evt;
    logic                     load_evt;
    logic                     last_smp;
    logic [15:0]              out_next;
    logic [4:0]               slot;
    logic [3:0]               bit_idx;
    logic                     sdata_d;

    assign sum_d    = acc_q + {{DECIM_LOG2{i_sample[15]}}, i_sample};
    assign avg_d    = sum_d >>> DECIM_LOG2;
    assign div_wrap = (div_q == DIV_LAST);
    assign fall_evt = div_wrap & bclk_q;
    assign f_d      = f_q + 6'd1;
    assign load_evt = fall_evt & (f_d == 6'd0);
    assign last_smp = i_sample_valid & (n_q == '1);

    // The load sees the pre-write holding register, so a same-cycle decimation
    // write is not consumed by this frame.
    assign out_next = (load_evt && pend_q) ? hold_q : out_q;
    assign slot     = f_d[4:0];
    assign bit_idx  = 4'(5'd16 - slot);

    always_comb begin
        sdata_d = 1'b0;
        if (slot >= 5'd1 && slot <= 5'd16) begin
            sdata_d = out_next[bit_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            n_q     <= '0;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            out_q   <= '0;
            div_q   <= '0;
            f_q     <= 6'd63;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            over_q  <= 1'b0;
            under_q <= 1'b0;

            if (div_wrap) begin
                div_q  <= '0;
                bclk_q <= ~bclk_q;
            end else begin
                div_q  <= div_q + 1'b1;
            end

            if (i_sample_valid) begin
                if (last_smp) begin
                    hold_q <= avg_d[15:0];
                    acc_q  <= '0;
                    n_q    <= '0;
                    over_q <= pend_q & ~load_evt;
                end else begin
                    acc_q  <= sum_d;
                    n_q    <= n_q + 1'b1;
                end
            end

            if (last_smp) begin
                pend_q <= 1'b1;
            end else if (load_evt) begin
                pend_q <= 1'b0;
            end

            if (fall_evt) begin
                f_q     <= f_d;
                lrclk_q <= f_d[5];
                sdata_q <= sdata_d;
                if (load_evt) begin
                    if (pend_q) begin
                        out_q <= hold_q;
                    end else begin
                        under_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_i2s_bclk  = bclk_q;
    assign o_i2s_lrclk = lrclk_q;
    assign o_i2s_sdata = sdata_q;
    assign o_overrun   = over_q;
    assign o_underrun  = under_q;

endmodule

`default_nettype wire

// File: tb/tb_sid_i2s_tx.sv
// Bench for sid_i2s_tx: table of decimation vectors, hand-made corner sequences
// and random traffic, all checked cycle by cycle against an arithmetic model.
`default_nettype none

module tb_sid_i2s_tx;

    localparam int BD = 2;
    localparam int DL = 2;
    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_sample;
    logic        i_sample_valid;
    logic        o_i2s_bclk;
    logic        o_i2s_lrclk;
    logic        o_i2s_sdata;
    logic        o_overrun;
    logic        o_underrun;

    always #5 clk = ~clk;

    sid_i2s_tx #(.BCLK_DIV(BD), .DECIM_LOG2(DL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .o_i2s_bclk     (o_i2s_bclk),
        .o_i2s_lrclk    (o_i2s_lrclk),
        .o_i2s_sdata    (o_i2s_sdata),
        .o_overrun      (o_overrun),
        .o_underrun     (o_underrun)
    );

    int tests = 0;
    int fails = 0;

    // Model state: e = clock edges since reset release, mf = current frame slot.
    int          e;
    int          mf;
    logic        mb, mlr, msd;
    logic [15:0] mout, mhold;
    logic        mpend;
    int          q[$];
    int          words = 0;
    int          ov_seen = 0;
    int          un_seen = 0;
    logic [15:0] cap;
    logic [15:0] last_word = 16'h0;

    typedef struct packed {
        logic [3:0][15:0] s;
        logic [15:0]      exp;
    } vec_t;

    function automatic void model_reset();
        e = 0; mf = 63; mb = 1'b0; mlr = 1'b0; msd = 1'b0;
        mout = 16'h0; mhold = 16'h0; mpend = 1'b0; cap = 16'h0;
        q.delete();
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // Called at a negedge; applies inputs for one posedge and checks all outputs.
    task automatic step(input logic v, input logic [15:0] s);
        logic fall, load, wr, eov, eun, prev_b;
        int sum, ss;
        logic [15:0] nv;
        logic [4:0] act, exv;
        i_sample_valid = v;
        i_sample = s;
        @(posedge clk);
        e++;
        prev_b = mb;
        mb = ((e / BD) % 2) == 1;
        fall = (e % (2 * BD)) == 0;
        load = 1'b0;
        wr = 1'b0;
        nv = 16'h0;
        if (fall) begin
            mf = (e / (2 * BD) - 1) % 64;
            load = (mf == 0);
        end
        if (v) begin
            q.push_back(int'($signed(s)));
            if (q.size() == NS) begin
                sum = 0;
                foreach (q[i]) sum += q[i];
                nv = 16'(sum >>> DL);
                wr = 1'b1;
                q.delete();
            end
        end
        eov = wr && mpend && !load;
        eun = load && !mpend;
        if (load && mpend) begin
            mout = mhold;
            mpend = 1'b0;
        end
        if (wr) begin
            mhold = nv;
            mpend = 1'b1;
        end
        if (fall) begin
            mlr = (mf >= 32);
            ss = mf % 32;
            msd = (ss >= 1 && ss <= 16) ? mout[16 - ss] : 1'b0;
        end
        #1;
        act = {o_i2s_bclk, o_i2s_lrclk, o_i2s_sdata, o_overrun, o_underrun};
        exv = {mb, mlr, msd, eov, eun};
        tests++;
        if (act !== exv) begin
            fails++;
            $display("FAIL cycle e=%0d f=%0d {bclk,lr,sd,ov,un}: got %b, want %b", e, mf, act, exv);
        end
        if (o_overrun)  ov_seen++;
        if (o_underrun) un_seen++;
        if (mb && !prev_b && mf >= 1 && mf <= 16) begin
            cap = {cap[14:0], o_i2s_sdata};
            if (mf == 16) begin
                last_word = cap;
                words++;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] s);
        step(1'b1, s);
        step(1'b0, 16'h0);
    endtask

    task automatic wait_f(input int target);
        int n = 0;
        while (mf != target && n < 2000) begin
            step(1'b0, 16'h0);
            n++;
        end
        if (mf != target) begin
            tests++; fails++;
            $display("FAIL wait_f timeout: f=%0d, want %0d", mf, target);
        end
    endtask

    task automatic wait_words(input int k);
        int w0 = words;
        int n = 0;
        while (words < w0 + k && n < 2000) begin
            step(1'b0, 16'h0);
            n++;
        end
        if (words < w0 + k) begin
            tests++; fails++;
            $display("FAIL wait_words timeout: got %0d words, want %0d", words - w0, k);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int ov0, un0, n;
        logic [15:0] prev;

        vecs[0] = '{s: {16'd400, 16'd300, 16'd200, 16'd100}, exp: 16'd250};
        vecs[1] = '{s: {16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF}, exp: 16'hFFFE};
        vecs[2] = '{s: {16'h8001, 16'h8001, 16'h8001, 16'h8001}, exp: 16'h8001};
        vecs[3] = '{s: {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, exp: 16'h7FFF};
        vecs[4] = '{s: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, exp: 16'h8000};
        vecs[5] = '{s: {16'd0, 16'd0, 16'd0, 16'd1}, exp: 16'h0000};
        vecs[6] = '{s: {16'd0, 16'd0, 16'd0, 16'hFFFF}, exp: 16'hFFFF};
        vecs[7] = '{s: {16'd2, 16'd3, 16'd3, 16'd3}, exp: 16'd2};

        rst_n = 1'b0;
        i_sample_valid = 1'b0;
        i_sample = 16'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", {11'h0, o_i2s_bclk, o_i2s_lrclk, o_i2s_sdata, o_overrun, o_underrun}, 16'h0);
        rst_n = 1'b1;

        // Table: four samples in one frame, averaged word appears in the next frame.
        for (int v = 0; v < 8; v++) begin
            wait_f(1);
            for (int j = 0; j < 4; j++) send(vecs[v].s[j]);
            wait_words(2);
            check($sformatf("decim_vec%0d", v), last_word, vecs[v].exp);
        end

        // Two decimations before one load: one overrun, second value sent.
        wait_f(1);
        ov0 = ov_seen;
        for (int j = 0; j < 4; j++) send(16'h1111);
        for (int j = 0; j < 4; j++) send(16'h2222);
        check("overrun_count", 16'(ov_seen - ov0), 16'd1);
        wait_words(2);
        check("overrun_word", last_word, 16'h2222);

        // No new sample: exactly one underrun and the word repeats.
        prev = last_word;
        wait_f(1);
        un0 = un_seen;
        wait_words(2);
        check("underrun_count", 16'(un_seen - un0), 16'd1);
        check("underrun_repeat", last_word, prev);

        // Decimation write landing on the frame-load edge.
        wait_f(1);
        for (int j = 0; j < 4; j++) send(16'h0AAA);
        for (int j = 0; j < 3; j++) send(16'h0555);
        ov0 = ov_seen;
        n = 0;
        while (!(((e + 1) % (2 * BD)) == 0 && (((e + 1) / (2 * BD) - 1) % 64) == 0) && n < 2000) begin
            step(1'b0, 16'h0);
            n++;
        end
        step(1'b1, 16'h0555);
        check("coincide_no_overrun", 16'(ov_seen - ov0), 16'd0);
        wait_words(1);
        check("coincide_first", last_word, 16'h0AAA);
        wait_words(1);
        check("coincide_second", last_word, 16'h0555);

        // Back-to-back strobes, each one accumulated.
        wait_f(1);
        for (int j = 0; j < 4; j++) step(1'b1, 16'(j * 8));
        step(1'b0, 16'h0);
        wait_words(2);
        check("b2b_word", last_word, 16'd12);

        // Asynchronous reset mid-frame with a partial accumulation outstanding.
        wait_f(18);
        send(16'h4000);
        send(16'h4000);
        wait_f(20);
        n = 0;
        while (!mb && n < 20) begin
            step(1'b0, 16'h0);
            n++;
        end
        check("pre_reset_bclk", {15'h0, o_i2s_bclk}, 16'h1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", {11'h0, o_i2s_bclk, o_i2s_lrclk, o_i2s_sdata, o_overrun, o_underrun}, 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        send(16'd10); send(16'd20); send(16'd30); send(16'd40);
        wait_words(2);
        check("post_reset_word", last_word, 16'd25);

        // Random traffic: fast rate provokes overruns, slow rate underruns.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 7) == 0, 16'($urandom));
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, 16'($urandom));
        check("random_saw_overrun", {15'h0, ov_seen > 0}, 16'h1);
        check("random_saw_underrun", {15'h0, un_seen > 0}, 16'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
